// File: rtl/seq_frame_tx.sv
// seq_frame_tx: serial frame transmitter.
// Each accepted byte goes out as a 4-bit preamble (MSB first), then the
// payload MSB first, then an optional even-parity bit. All outputs are
// registered; tx_ready is decoded from the state register only.
module seq_frame_tx #(
  parameter logic [3:0] PREAMBLE = 4'b1011,
  parameter bit         PAR_EN   = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       out,
  output logic       tx_active,
  output logic       tx_done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PRE  = 2'd1,
    DATA = 2'd2,
    PAR  = 2'd3
  } state_t;

  state_t     state_r;
  logic [2:0] cnt_r;      // index of the bit currently on out within PRE/DATA
  logic [7:0] shreg_r;    // payload; bit 7 is the next payload bit to send
  logic       par_r;      // even parity of the latched payload
  logic       out_r;
  logic       active_r;
  logic       done_r;
  logic       pre_bit_s;  // preamble bit that follows the one now on out

  // Even parity of a payload byte.
  function automatic logic even_parity(input logic [7:0] d);
    return ^d;
  endfunction

  // Select the next preamble bit from the bit currently being driven.
  always_comb begin
    pre_bit_s = 1'b0;
    case (cnt_r)
      3'd0:    pre_bit_s = PREAMBLE[2];
      3'd1:    pre_bit_s = PREAMBLE[1];
      3'd2:    pre_bit_s = PREAMBLE[0];
      default: pre_bit_s = 1'b0;
    endcase
  end

  // Frame sequencer: state, counter, shift register and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r  <= IDLE;
      cnt_r    <= 3'd0;
      shreg_r  <= 8'h00;
      par_r    <= 1'b0;
      out_r    <= 1'b0;
      active_r <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          cnt_r <= 3'd0;
          if (tx_valid) begin
            state_r  <= PRE;
            shreg_r  <= tx_data;
            par_r    <= even_parity(tx_data);
            out_r    <= PREAMBLE[3];
            active_r <= 1'b1;
            done_r   <= 1'b0;
          end else begin
            out_r    <= 1'b0;
            active_r <= 1'b0;
            done_r   <= 1'b0;
          end
        end
        PRE: begin
          done_r <= 1'b0;
          if (cnt_r == 3'd3) begin
            state_r <= DATA;
            cnt_r   <= 3'd0;
            out_r   <= shreg_r[7];
            shreg_r <= {shreg_r[6:0], 1'b0};
          end else begin
            cnt_r <= cnt_r + 3'd1;
            out_r <= pre_bit_s;
          end
        end
        DATA: begin
          if (cnt_r == 3'd7) begin
            cnt_r <= 3'd0;
            if (PAR_EN) begin
              state_r <= PAR;
              out_r   <= par_r;
              done_r  <= 1'b1;
            end else begin
              state_r  <= IDLE;
              out_r    <= 1'b0;
              active_r <= 1'b0;
              done_r   <= 1'b0;
            end
          end else begin
            cnt_r   <= cnt_r + 3'd1;
            out_r   <= shreg_r[7];
            shreg_r <= {shreg_r[6:0], 1'b0};
            // Without parity, D[0] is the last frame bit.
            done_r  <= (PAR_EN == 1'b0) && (cnt_r == 3'd6);
          end
        end
        PAR: begin
          state_r  <= IDLE;
          cnt_r    <= 3'd0;
          out_r    <= 1'b0;
          active_r <= 1'b0;
          done_r   <= 1'b0;
        end
        default: begin
          state_r  <= IDLE;
          cnt_r    <= 3'd0;
          out_r    <= 1'b0;
          active_r <= 1'b0;
          done_r   <= 1'b0;
        end
      endcase
    end
  end

  assign tx_ready  = (state_r == IDLE);
  assign out       = out_r;
  assign tx_active = active_r;
  assign tx_done   = done_r;

endmodule

// File: tb/tb_seq_frame_tx.sv
// Self-checking bench for seq_frame_tx: one instance with parity, one without.
// Expected frame bits are pushed to a queue at stimulus time and popped each
// cycle while the frame is on the wire.
module tb_seq_frame_tx;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] tx_data, tx_data0;
  logic       tx_valid, tx_valid0;
  logic       tx_ready, out, tx_active, tx_done;
  logic       tx_ready0, out0, tx_active0, tx_done0;

  int checks = 0;
  int passed = 0;

  // Each entry: {expected out bit, expected tx_done}
  logic [1:0] q[$];
  logic [1:0] q0[$];

  seq_frame_tx #(.PREAMBLE(4'b1011), .PAR_EN(1'b1)) dut (
    .clk(clk), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .out(out), .tx_active(tx_active), .tx_done(tx_done)
  );

  seq_frame_tx #(.PREAMBLE(4'b1011), .PAR_EN(1'b0)) dut0 (
    .clk(clk), .reset(reset), .tx_data(tx_data0), .tx_valid(tx_valid0),
    .tx_ready(tx_ready0), .out(out0), .tx_active(tx_active0), .tx_done(tx_done0)
  );

  always #5 clk = ~clk;

  // Push n expected bits (MSB first); tx_done expected on the last one only.
  task automatic push_bits(input logic [12:0] bits, input int n, input bit to_nopar);
    for (int i = n - 1; i >= 0; i--) begin
      if (to_nopar) q0.push_back({bits[i], (i == 0) ? 1'b1 : 1'b0});
      else          q.push_back({bits[i], (i == 0) ? 1'b1 : 1'b0});
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tx_valid = 1'b0; tx_data = 8'h00; tx_valid0 = 1'b0; tx_data0 = 8'h00;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if ({out, tx_ready, tx_active, tx_done} !== 4'b0100)
        $display("FAIL reset_hold out/ready/active/done got %b want 0100",
                 {out, tx_ready, tx_active, tx_done});
      else passed++;
      checks++;
      if ({out0, tx_ready0, tx_active0, tx_done0} !== 4'b0100)
        $display("FAIL reset_hold_nopar got %b want 0100",
                 {out0, tx_ready0, tx_active0, tx_done0});
      else passed++;
    end
    reset = 1'b0;
  endtask

  // Send one byte on the parity instance, check every frame bit and the idle after.
  task automatic test_single(input string name, input logic [7:0] d, input logic [12:0] exp);
    logic [1:0] e;
    checks++;
    if (tx_ready !== 1'b1) $display("FAIL %s_ready got %b want 1", name, tx_ready);
    else passed++;
    tx_data = d; tx_valid = 1'b1;
    push_bits(exp, 13, 1'b0);
    while (q.size() > 0) begin
      @(negedge clk);
      tx_valid = 1'b0;
      e = q.pop_front();
      checks++;
      if ({out, tx_active, tx_done} !== {e[1], 1'b1, e[0]})
        $display("FAIL %s_bit%0d out/active/done got %b want %b",
                 name, 12 - q.size(), {out, tx_active, tx_done}, {e[1], 1'b1, e[0]});
      else passed++;
    end
    @(negedge clk);
    checks++;
    if ({out, tx_active, tx_done, tx_ready} !== 4'b0001)
      $display("FAIL %s_idle out/active/done/ready got %b want 0001",
               name, {out, tx_active, tx_done, tx_ready});
    else passed++;
  endtask

  task automatic test_back_to_back();
    logic [1:0] e;
    int k;
    tx_data = 8'h3C; tx_valid = 1'b1;
    push_bits(13'b1011_00111100_0, 13, 1'b0);
    k = 0;
    while (q.size() > 0) begin
      @(negedge clk);
      k++;
      if (k == 3) tx_data = 8'hFF;  // mid-frame change must not disturb frame 1
      e = q.pop_front();
      checks++;
      if ({out, tx_active, tx_done} !== {e[1], 1'b1, e[0]})
        $display("FAIL b2b_f1_bit%0d got %b want %b", k, {out, tx_active, tx_done},
                 {e[1], 1'b1, e[0]});
      else passed++;
    end
    @(negedge clk);
    checks++;
    if ({out, tx_active, tx_done, tx_ready} !== 4'b0001)
      $display("FAIL b2b_gap out/active/done/ready got %b want 0001",
               {out, tx_active, tx_done, tx_ready});
    else passed++;
    push_bits(13'b1011_11111111_0, 13, 1'b0);
    k = 0;
    while (q.size() > 0) begin
      @(negedge clk);
      k++;
      if (k == 3) begin
        tx_data = 8'h00;
        tx_valid = 1'b0;
      end
      e = q.pop_front();
      checks++;
      if ({out, tx_active, tx_done} !== {e[1], 1'b1, e[0]})
        $display("FAIL b2b_f2_bit%0d got %b want %b", k, {out, tx_active, tx_done},
                 {e[1], 1'b1, e[0]});
      else passed++;
    end
    @(negedge clk);
    checks++;
    if ({out, tx_active, tx_done, tx_ready} !== 4'b0001)
      $display("FAIL b2b_end got %b want 0001", {out, tx_active, tx_done, tx_ready});
    else passed++;
  endtask

  task automatic test_reset_mid_frame();
    logic [1:0] e;
    tx_data = 8'hA5; tx_valid = 1'b1;
    push_bits(13'b1011_10100101_0, 13, 1'b0);
    for (int i = 1; i <= 8; i++) begin  // cycle 8 carries D[4]
      @(negedge clk);
      tx_valid = 1'b0;
      e = q.pop_front();
      checks++;
      if ({out, tx_active, tx_done} !== {e[1], 1'b1, e[0]})
        $display("FAIL midrst_bit%0d got %b want %b", i, {out, tx_active, tx_done},
                 {e[1], 1'b1, e[0]});
      else passed++;
    end
    #1 reset = 1'b1;
    #1;
    checks++;
    if ({out, tx_ready, tx_active, tx_done} !== 4'b0100)
      $display("FAIL midrst_async out/ready/active/done got %b want 0100",
               {out, tx_ready, tx_active, tx_done});
    else passed++;
    q.delete();
    repeat (2) begin
      @(negedge clk);
      checks++;
      if ({out, tx_ready, tx_active, tx_done} !== 4'b0100)
        $display("FAIL midrst_held got %b want 0100", {out, tx_ready, tx_active, tx_done});
      else passed++;
    end
    reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if ({out, tx_active, tx_done, tx_ready} !== 4'b0001)
        $display("FAIL midrst_noresume got %b want 0001", {out, tx_active, tx_done, tx_ready});
      else passed++;
    end
  endtask

  task automatic test_no_parity();
    logic [1:0] e;
    checks++;
    if (tx_ready0 !== 1'b1) $display("FAIL nopar_ready got %b want 1", tx_ready0);
    else passed++;
    tx_data0 = 8'hF0; tx_valid0 = 1'b1;
    push_bits(13'b0_1011_11110000, 12, 1'b1);
    while (q0.size() > 0) begin
      @(negedge clk);
      tx_valid0 = 1'b0;
      tx_data0 = 8'h0F;
      e = q0.pop_front();
      checks++;
      if ({out0, tx_active0, tx_done0} !== {e[1], 1'b1, e[0]})
        $display("FAIL nopar_bit%0d got %b want %b", 11 - q0.size(),
                 {out0, tx_active0, tx_done0}, {e[1], 1'b1, e[0]});
      else passed++;
    end
    repeat (2) begin
      @(negedge clk);
      checks++;
      if ({out0, tx_active0, tx_done0, tx_ready0} !== 4'b0001)
        $display("FAIL nopar_idle got %b want 0001", {out0, tx_active0, tx_done0, tx_ready0});
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_single("a5_first", 8'hA5, 13'b1011_10100101_0);
    test_single("x01", 8'h01, 13'b1011_00000001_1);
    test_back_to_back();
    test_reset_mid_frame();
    test_single("a5_after_rst", 8'hA5, 13'b1011_10100101_0);
    test_no_parity();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
